// File: rtl/flit_sink.sv
// Receive-side flit endpoint: checks packet framing, counts packets/flits, and accumulates payload toggles.
// Optional FLIT_SINK_CHKSUM_EN adds a per-packet XOR checksum output (chksum).
//
// state  | meaning
// S_IDLE | between packets, waiting for HEAD
// S_BODY | inside a packet, accepting DATA until TAIL
module flit_sink #(
  parameter int DATA_W  = 67,
  parameter int TYPE_W  = 3,
  parameter int VCH_W   = 2,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivalid,
  input  logic [VCH_W-1:0]  ivch,
  input  logic              clr,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  flit_cnt,
  output logic [CNT_W-1:0]  toggle_cnt,
  output logic [7:0]        last_len,
  output logic              pkt_done,
  output logic              err_seq,
  output logic              err_vch,
  output logic              err_len,
  output logic              busy
`ifdef FLIT_SINK_CHKSUM_EN
  ,
  output logic [63:0]       chksum
`endif
);

  localparam int PAY_W = DATA_W - TYPE_W;
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  // Codes other than HEAD/DATA/TAIL are ignored like TYPE_NONE.
  localparam logic [TYPE_W-1:0] TYPE_NONE = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] TYPE_HEAD = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] TYPE_DATA = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] TYPE_TAIL = TYPE_W'(3);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [VCH_W-1:0]   vch_q, vch_d;
  logic [PAY_W-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
  logic [CNT_W-1:0]   toggle_cnt_q, toggle_cnt_d;
  logic [7:0]         last_len_q, last_len_d;
  logic               pkt_done_q, pkt_done_d;
  logic               err_seq_q, err_seq_d;
  logic               err_vch_q, err_vch_d;
  logic               err_len_q, err_len_d;
`ifdef FLIT_SINK_CHKSUM_EN
  logic [PAY_W-1:0]   acc_q, acc_d;
  logic [63:0]        chksum_q, chksum_d;
`endif

  logic [TYPE_W-1:0]  ftype;
  logic [PAY_W-1:0]   payload;
  logic               take;
  logic               inc_flit;
  logic               inc_pkt;
  logic               set_err_len;
  logic [7:0]         last_val;
  logic [CNT_W-1:0]   tog_add;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    ftype        = idata[DATA_W-1 -: TYPE_W];
    payload      = idata[PAY_W-1:0];
    take         = ivalid && ftype != TYPE_NONE &&
                   (ftype == TYPE_HEAD || ftype == TYPE_DATA || ftype == TYPE_TAIL);
    state_d      = state_q;
    len_d        = len_q;
    vch_d        = vch_q;
    prev_d       = prev_q;
    pkt_cnt_d    = pkt_cnt_q;
    flit_cnt_d   = flit_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    last_len_d   = last_len_q;
    err_len_d    = err_len_q;
    pkt_done_d   = 1'b0;
    err_seq_d    = 1'b0;
    err_vch_d    = 1'b0;
    inc_flit     = 1'b0;
    inc_pkt      = 1'b0;
    set_err_len  = 1'b0;
    last_val     = last_len_q;
    tog_add      = '0;

    if (take) begin
      tog_add = CNT_W'($countones(payload ^ prev_q));
      prev_d  = payload;
      case (state_q)
        S_IDLE: begin
          if (ftype == TYPE_HEAD) begin
            state_d  = S_BODY;
            len_d    = 8'd1;
            vch_d    = ivch;
            inc_flit = 1'b1;
          end else begin
            err_seq_d = 1'b1;
          end
        end
        S_BODY: begin
          err_vch_d = (ivch != vch_q);
          inc_flit  = 1'b1;
          if (ftype == TYPE_HEAD) begin
            // Unterminated packet is discarded; the new HEAD starts over.
            err_seq_d = 1'b1;
            len_d     = 8'd1;
            vch_d     = ivch;
          end else if (ftype == TYPE_DATA) begin
            if (len_q == LEN_MAX) set_err_len = 1'b1;
            else                  len_d = len_q + 8'd1;
          end else begin
            inc_pkt    = 1'b1;
            pkt_done_d = 1'b1;
            state_d    = S_IDLE;
            len_d      = 8'd0;
            if (len_q == LEN_MAX) begin
              set_err_len = 1'b1;
              last_val    = LEN_MAX;
            end else begin
              last_val    = len_q + 8'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (clr) begin
      pkt_cnt_d    = '0;
      flit_cnt_d   = '0;
      toggle_cnt_d = '0;
      last_len_d   = '0;
      err_len_d    = 1'b0;
    end else begin
      pkt_cnt_d    = sat_add(pkt_cnt_q, CNT_W'(inc_pkt));
      flit_cnt_d   = sat_add(flit_cnt_q, CNT_W'(inc_flit));
      toggle_cnt_d = sat_add(toggle_cnt_q, tog_add);
      if (inc_pkt)     last_len_d = last_val;
      if (set_err_len) err_len_d  = 1'b1;
    end

`ifdef FLIT_SINK_CHKSUM_EN
    acc_d    = acc_q;
    chksum_d = chksum_q;
    if (take && ftype == TYPE_HEAD)
      acc_d = payload;
    else if (take && state_q == S_BODY && ftype == TYPE_DATA)
      acc_d = acc_q ^ payload;
    if (inc_pkt) chksum_d = 64'(acc_q ^ payload);
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      vch_q        <= '0;
      prev_q       <= '0;
      pkt_cnt_q    <= '0;
      flit_cnt_q   <= '0;
      toggle_cnt_q <= '0;
      last_len_q   <= '0;
      pkt_done_q   <= 1'b0;
      err_seq_q    <= 1'b0;
      err_vch_q    <= 1'b0;
      err_len_q    <= 1'b0;
`ifdef FLIT_SINK_CHKSUM_EN
      acc_q        <= '0;
      chksum_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      vch_q        <= vch_d;
      prev_q       <= prev_d;
      pkt_cnt_q    <= pkt_cnt_d;
      flit_cnt_q   <= flit_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      last_len_q   <= last_len_d;
      pkt_done_q   <= pkt_done_d;
      err_seq_q    <= err_seq_d;
      err_vch_q    <= err_vch_d;
      err_len_q    <= err_len_d;
`ifdef FLIT_SINK_CHKSUM_EN
      acc_q        <= acc_d;
      chksum_q     <= chksum_d;
`endif
    end
  end

  assign pkt_cnt    = pkt_cnt_q;
  assign flit_cnt   = flit_cnt_q;
  assign toggle_cnt = toggle_cnt_q;
  assign last_len   = last_len_q;
  assign pkt_done   = pkt_done_q;
  assign err_seq    = err_seq_q;
  assign err_vch    = err_vch_q;
  assign err_len    = err_len_q;
  assign busy       = (state_q == S_BODY);
`ifdef FLIT_SINK_CHKSUM_EN
  assign chksum     = chksum_q;
`endif

endmodule

// File: tb/tb_flit_sink.sv
// Self-checking bench for flit_sink: vector table, directed corner sequences, randomized run vs. packet-level model.
module tb_flit_sink;
  localparam int DATA_W  = 67;
  localparam int TYPE_W  = 3;
  localparam int VCH_W   = 2;
  localparam int MAX_LEN = 64;
  localparam int CNT_W   = 32;
  localparam logic [2:0] T_NONE = 3'd0, T_HEAD = 3'd1, T_DATA = 3'd2, T_TAIL = 3'd3;
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

  logic              clk, rst_;
  logic [DATA_W-1:0] idata;
  logic              ivalid, clr;
  logic [VCH_W-1:0]  ivch;
  logic [CNT_W-1:0]  pkt_cnt, flit_cnt, toggle_cnt;
  logic [7:0]        last_len;
  logic              pkt_done, err_seq, err_vch, err_len, busy;
`ifdef FLIT_SINK_CHKSUM_EN
  logic [63:0]       chksum;
`endif

  flit_sink #(.DATA_W(DATA_W), .TYPE_W(TYPE_W), .VCH_W(VCH_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt), .toggle_cnt(toggle_cnt), .last_len(last_len),
    .pkt_done(pkt_done), .err_seq(err_seq), .err_vch(err_vch), .err_len(err_len), .busy(busy)
`ifdef FLIT_SINK_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_done = 0, n_seq = 0, n_vch = 0;

  typedef struct {
    logic [2:0] t; logic [63:0] p; logic [1:0] v; logic val; logic c;
    logic e_done; logic e_seq; logic e_vch; logic e_busy;
    int e_pkt; int e_flit; int e_tog; int e_last;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] t, input logic [63:0] p, input logic [1:0] v,
                      input logic val, input logic c);
    idata = {t, p}; ivch = v; ivalid = val; clr = c;
    @(posedge clk); #1;
    n_done += int'(pkt_done); n_seq += int'(err_seq); n_vch += int'(err_vch);
    ivalid = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_ = 1'b1;
    n_done = 0; n_seq = 0; n_vch = 0;
  endtask

  function automatic int pop(input logic [63:0] x);
    int n = 0;
    while (x != 0) begin x &= x - 64'd1; n++; end
    return n;
  endfunction

  function automatic longint sat32(input longint x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // packet-level reference state
  bit in_pkt; int mlen; logic [1:0] mvch; logic [63:0] mprev;
  longint mpkt, mflit, mtog; int mlast; bit merr;

  initial begin
    bit e_done, e_seq, e_vch, errset;
    int fi, pi, ta, newlast, r, tail_pct, head_pct;
    logic [2:0] t; logic [63:0] p; logic [1:0] v, cur_v; logic val, c;

    rst_ = 1'b1; idata = '0; ivalid = 1'b0; ivch = '0; clr = 1'b0;
    #2 rst_ = 1'b0;
    #3;
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_len", err_len, 0);
    @(posedge clk); #1 rst_ = 1'b1;

    // vector table
    vecs[0]  = '{T_DATA, 64'h5, 2'd0, 1'b1, 1'b0, 0, 1, 0, 0, 0, 0, 2, 0};
    vecs[1]  = '{T_TAIL, 64'h5, 2'd0, 1'b1, 1'b0, 0, 1, 0, 0, 0, 0, 2, 0};
    vecs[2]  = '{T_HEAD, 64'hFF, 2'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 2, 0};
    vecs[3]  = '{T_NONE, 64'hFF, 2'd0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 2, 0};
    vecs[4]  = '{T_HEAD, 64'h0, 2'd1, 1'b1, 1'b0, 0, 0, 0, 1, 0, 1, 4, 0};
    vecs[5]  = '{T_DATA, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 1'b0, 0, 0, 0, 1, 0, 2, 68, 0};
    vecs[6]  = '{T_TAIL, 64'h0, 2'd1, 1'b1, 1'b0, 1, 0, 0, 0, 1, 3, 132, 3};
    vecs[7]  = '{T_HEAD, 64'h0, 2'd1, 1'b1, 1'b0, 0, 0, 0, 1, 1, 4, 132, 3};
    vecs[8]  = '{T_DATA, 64'h0, 2'd2, 1'b1, 1'b0, 0, 0, 1, 1, 1, 5, 132, 3};
    vecs[9]  = '{T_TAIL, 64'h0, 2'd1, 1'b1, 1'b0, 1, 0, 0, 0, 2, 6, 132, 3};
    vecs[10] = '{T_HEAD, 64'h0, 2'd0, 1'b1, 1'b1, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{T_TAIL, 64'h0, 2'd0, 1'b1, 1'b0, 1, 0, 0, 0, 1, 1, 0, 2};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].t, vecs[i].p, vecs[i].v, vecs[i].val, vecs[i].c);
      chk($sformatf("vec%0d_pkt_done", i), pkt_done, vecs[i].e_done);
      chk($sformatf("vec%0d_err_seq", i), err_seq, vecs[i].e_seq);
      chk($sformatf("vec%0d_err_vch", i), err_vch, vecs[i].e_vch);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, 64'(vecs[i].e_pkt));
      chk($sformatf("vec%0d_flit_cnt", i), flit_cnt, 64'(vecs[i].e_flit));
      chk($sformatf("vec%0d_toggle_cnt", i), toggle_cnt, 64'(vecs[i].e_tog));
      chk($sformatf("vec%0d_last_len", i), last_len, 64'(vecs[i].e_last));
    end

    // clean 22-flit packet
    do_reset();
    step(T_HEAD, 64'h9, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(T_DATA, 64'h9, 2'd0, 1'b1, 1'b0);
    step(T_TAIL, 64'h9, 2'd0, 1'b1, 1'b0);
    chk("clean_done_pulses", n_done, 1);
    chk("clean_err_pulses", n_seq + n_vch, 0);
    chk("clean_pkt_cnt", pkt_cnt, 1);
    chk("clean_flit_cnt", flit_cnt, 22);
    chk("clean_last_len", last_len, 22);

    // HEAD inside packet
    do_reset();
    step(T_HEAD, 64'h1, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(T_DATA, 64'h2, 2'd0, 1'b1, 1'b0);
    step(T_HEAD, 64'h3, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(T_DATA, 64'h4, 2'd0, 1'b1, 1'b0);
    step(T_TAIL, 64'h5, 2'd0, 1'b1, 1'b0);
    chk("rehead_err_seq", n_seq, 1);
    chk("rehead_pkt_cnt", pkt_cnt, 1);
    chk("rehead_last_len", last_len, 4);
    chk("rehead_flit_cnt", flit_cnt, 8);

    // length overflow, then clr
    do_reset();
    step(T_HEAD, 64'h0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) step(T_DATA, 64'h0, 2'd0, 1'b1, 1'b0);
    chk("len_at_max_no_err", err_len, 0);
    step(T_DATA, 64'h0, 2'd0, 1'b1, 1'b0);
    chk("len_exceed_err", err_len, 1);
    for (int i = 0; i < 6; i++) step(T_DATA, 64'h0, 2'd0, 1'b1, 1'b0);
    step(T_TAIL, 64'h0, 2'd0, 1'b1, 1'b0);
    chk("ovf_err_len", err_len, 1);
    chk("ovf_last_len", last_len, 64);
    chk("ovf_pkt_cnt", pkt_cnt, 1);
    chk("ovf_flit_cnt", flit_cnt, 72);
    step(T_NONE, 64'h0, 2'd0, 1'b0, 1'b1);
    chk("clr_err_len", err_len, 0);
    chk("clr_last_len", last_len, 0);

    // reset mid-packet
    do_reset();
    step(T_HEAD, 64'h3, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(T_DATA, 64'hF0 + 64'(i), 2'd0, 1'b1, 1'b0);
    rst_ = 1'b0;
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flit_cnt", flit_cnt, 0);
    chk("mid_rst_toggle_cnt", toggle_cnt, 0);
    @(posedge clk); #1 rst_ = 1'b1;
    n_seq = 0; n_done = 0;
    step(T_TAIL, 64'h0, 2'd0, 1'b1, 1'b0);
    chk("post_rst_tail_err_seq", n_seq, 1);
    step(T_HEAD, 64'h0, 2'd0, 1'b1, 1'b0);
    step(T_DATA, 64'h0, 2'd0, 1'b1, 1'b0);
    step(T_TAIL, 64'h0, 2'd0, 1'b1, 1'b0);
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("post_rst_last_len", last_len, 3);
    chk("post_rst_flit_cnt", flit_cnt, 3);

`ifdef FLIT_SINK_CHKSUM_EN
    do_reset();
    step(T_HEAD, 64'hA, 2'd0, 1'b1, 1'b0);
    step(T_DATA, 64'h5, 2'd0, 1'b1, 1'b0);
    step(T_TAIL, 64'hF, 2'd0, 1'b1, 1'b0);
    chk("chksum_zero", chksum, 64'h0);
    step(T_HEAD, 64'h1, 2'd0, 1'b1, 1'b0);
    step(T_DATA, 64'h2, 2'd0, 1'b1, 1'b0);
    step(T_TAIL, 64'h4, 2'd0, 1'b1, 1'b0);
    chk("chksum_seven", chksum, 64'h7);
`endif

    // randomized run against packet-level model
    do_reset();
    in_pkt = 0; mlen = 0; mvch = 0; mprev = 0;
    mpkt = 0; mflit = 0; mtog = 0; mlast = 0; merr = 0;
    cur_v = 2'd0;
    for (int i = 0; i < 600; i++) begin
      tail_pct = (i < 300) ? 15 : 1;
      head_pct = (i < 300) ? 8 : 1;
      r = int'($urandom_range(0, 99));
      if (r < head_pct)                 t = T_HEAD;
      else if (r < head_pct + tail_pct) t = T_TAIL;
      else if (r < 95)                  t = T_DATA;
      else                              t = T_NONE;
      p = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) cur_v = 2'($urandom_range(0, 3));
      v = cur_v;
      val = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 49) == 0);

      e_done = 0; e_seq = 0; e_vch = 0; errset = 0; fi = 0; pi = 0; ta = 0; newlast = 0;
      if (val && (t == T_HEAD || t == T_DATA || t == T_TAIL)) begin
        ta = pop(p ^ mprev);
        mprev = p;
        if (!in_pkt) begin
          if (t == T_HEAD) begin in_pkt = 1; mlen = 1; mvch = v; fi = 1; end
          else e_seq = 1;
        end else begin
          e_vch = (v != mvch);
          fi = 1;
          if (t == T_HEAD) begin e_seq = 1; mlen = 1; mvch = v; end
          else if (t == T_DATA) begin
            if (mlen + 1 > MAX_LEN) errset = 1; else mlen = mlen + 1;
          end else begin
            pi = 1; e_done = 1; in_pkt = 0;
            if (mlen + 1 > MAX_LEN) errset = 1;
            newlast = (mlen + 1 > MAX_LEN) ? MAX_LEN : mlen + 1;
          end
        end
      end
      if (c) begin
        mpkt = 0; mflit = 0; mtog = 0; mlast = 0; merr = 0;
      end else begin
        mpkt = sat32(mpkt + pi);
        mflit = sat32(mflit + fi);
        mtog = sat32(mtog + ta);
        if (e_done) mlast = newlast;
        if (errset) merr = 1;
      end

      step(t, p, v, val, c);
      chk("rnd_pkt_done", pkt_done, e_done);
      chk("rnd_err_seq", err_seq, e_seq);
      chk("rnd_err_vch", err_vch, e_vch);
      chk("rnd_err_len", err_len, merr);
      chk("rnd_busy", busy, in_pkt);
      chk("rnd_pkt_cnt", pkt_cnt, 64'(mpkt));
      chk("rnd_flit_cnt", flit_cnt, 64'(mflit));
      chk("rnd_toggle_cnt", toggle_cnt, 64'(mtog));
      chk("rnd_last_len", last_len, 64'(mlast));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flit_sink.md
Name: flit_sink

Overview:
- Receive-side endpoint for the router flit interface; consumes the {data, valid, vch} flit stream driven out of a mux or router output port.
- Checks HEAD/DATA/TAIL packet framing and counts packets and flits.
- Accumulates payload bit-toggle activity (Hamming distance between consecutive valid flits) for energy characterization runs.
- Sits at the output port of the device under characterization, in place of a downstream router input.

Parameters:
- DATA_W, 67, flit width: TYPE field in MSBs plus 64-bit payload.
- TYPE_W, 3, width of flit TYPE field, located at [DATA_W-1:DATA_W-TYPE_W].
- VCH_W, 2, virtual-channel id width.
- MAX_LEN, 64, maximum legal flits per packet, including HEAD and TAIL.
- CNT_W, 32, width of all statistics counters.

Ports:
- clk, input, 1, clock, rising edge.
- rst_, input, 1, reset, asynchronous, active-low.
- idata, input, DATA_W, incoming flit.
- ivalid, input, 1, flit qualifier.
- ivch, input, VCH_W, virtual channel of flit.
- clr, input, 1, synchronous clear of all statistics; FSM unaffected.
- pkt_cnt, output, CNT_W, completed packets.
- flit_cnt, output, CNT_W, flits accepted inside packets.
- toggle_cnt, output, CNT_W, accumulated payload bit toggles.
- last_len, output, 8, length of the last completed packet.
- pkt_done, output, 1, one-cycle pulse on TAIL acceptance.
- err_seq, output, 1, one-cycle pulse on a framing error.
- err_vch, output, 1, one-cycle pulse on a VCH change inside a packet.
- err_len, output, 1, sticky; packet exceeded MAX_LEN; cleared by clr.
- busy, output, 1, FSM in BODY.

Behaviour:
- Reset (rst_ low, asynchronous):
  - All counters, last_len, the prev-payload register and the length register go to 0.
  - All pulses, err_len and busy go to 0; FSM goes to IDLE.
  - Release is synchronous to clk.
- Sampling and latency:
  - A flit is sampled only when ivalid=1.
  - Flits whose TYPE is `TYPE_NONE are ignored entirely: no count, no toggle, no state change.
  - All outputs are registered; effects appear one cycle after the sampling edge.
- Toggle accounting:
  - Every sampled non-NONE flit adds popcount(idata[DATA_W-TYPE_W-1:0] ^ prev) to toggle_cnt, then loads prev with that payload.
  - prev is 0 after reset.
  - Toggle accounting applies to flits flagged err_seq too.
- FSM, IDLE state:
  - HEAD: go to BODY, len=1, latch cur_vch=ivch, flit_cnt+1.
  - DATA or TAIL: err_seq pulse, stay in IDLE, flit_cnt unchanged.
- FSM, BODY state:
  - DATA: len+1, flit_cnt+1.
  - TAIL: flit_cnt+1, pkt_cnt+1, last_len=len+1, pkt_done pulse, go to IDLE.
  - HEAD: err_seq pulse; the previous packet is dropped and not counted; restart with len=1, new cur_vch, flit_cnt+1, stay in BODY.
  - Any flit with ivch != cur_vch: err_vch pulse; the flit is still processed normally.
- Length limit:
  - len saturates at MAX_LEN.
  - An attempt to exceed MAX_LEN sets err_len; the packet still completes on TAIL with last_len=MAX_LEN.
- Counter width: all counters saturate at all-ones; no wrap.
- clr:
  - Zeroes counters, last_len and err_len in the same cycle.
  - Takes priority over any simultaneous increment; the flit's count and toggle contributions in that cycle are discarded.
  - FSM and prev are untouched.

Optional Feature:
- Macro: FLIT_SINK_CHKSUM_EN.
- When defined:
  - Adds output chksum[63:0], a running XOR of payloads from HEAD through TAIL.
  - Latched on TAIL together with pkt_done; reset value 0.
  - The accumulator reloads on every HEAD.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Clean packet: HEAD (payload 0x9), 20 DATA, TAIL on vch 0 -> pkt_done once, pkt_cnt=1, flit_cnt=22, last_len=22, no error pulses.
- Toggle counting: HEAD payload 0, then DATA payload 64'hFFFF_FFFF_FFFF_FFFF, then TAIL payload 0 -> toggle_cnt=128.
- Orphan flits: DATA then TAIL while IDLE -> two err_seq pulses, pkt_cnt=0, flit_cnt=0, busy stays 0.
- HEAD inside packet: HEAD, 3 DATA, HEAD, 2 DATA, TAIL -> one err_seq, pkt_cnt=1, last_len=4, flit_cnt=8.
- VCH mismatch and length overflow: HEAD vch1, DATA vch2, TAIL vch1 -> one err_vch, pkt_cnt=1, last_len=3. Separately, HEAD + 70 DATA + TAIL with MAX_LEN=64 -> err_len=1, last_len=64.
- Reset mid-packet: rst_ low after HEAD + 5 DATA, then release -> all outputs 0 immediately. A following TAIL gives err_seq; a following full packet counts normally.
- FLIT_SINK_CHKSUM_EN defined: payloads 0xA, 0x5, 0xF -> chksum=0x0.
